// File: rtl/ccc_cfg_pkg.sv
// Shared types and constants for the CCC dynamic-reconfiguration APB master.
package ccc_cfg_pkg;

  localparam int APB_AW = 6;
  localparam int APB_DW = 8;

  typedef enum logic [3:0] {
    IDLE,
    PLL_HOLD,
    W_SETUP,
    W_ACCESS,
    R_SETUP,
    R_ACCESS,
    RELEASE,
    WAIT_LOCK,
    SUCCESS,
    FAIL
  } state_t;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_MISMATCH = 2'd1;
  localparam logic [1:0] ERR_LOCK_TMO = 2'd2;
  localparam logic [1:0] ERR_BUSY_TMO = 2'd3;

  // States in which an APB transfer is in flight (PSEL high).
  function automatic logic in_apb(input state_t s);
    return s inside {W_SETUP, W_ACCESS, R_SETUP, R_ACCESS};
  endfunction

  // States in which the PLL is held in reset.
  function automatic logic holds_pll(input state_t s);
    return s inside {PLL_HOLD, W_SETUP, W_ACCESS, R_SETUP, R_ACCESS};
  endfunction

endpackage

// File: rtl/ccc_lock_qualifier.sv
// Synchronises the PLL LOCK flag and qualifies it: lock is declared after
// LOCK_STABLE consecutive high cycles; timeout fires on the cycle the
// enabled-cycle count reaches LOCK_TIMEOUT.
module ccc_lock_qualifier #(
  parameter int LOCK_TIMEOUT = 4096,
  parameter int LOCK_STABLE  = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic lock,
  input  logic clear,
  input  logic enable,
  output logic locked,
  output logic timeout
);

  localparam int SW = $clog2(LOCK_STABLE + 1);
  localparam int TW = $clog2(LOCK_TIMEOUT + 1);
  localparam logic [SW-1:0] STABLE_MAX = SW'(LOCK_STABLE);
  localparam logic [TW-1:0] TMO_MAX    = TW'(LOCK_TIMEOUT);
  localparam logic [TW-1:0] TMO_LAST   = TW'(LOCK_TIMEOUT - 1);

  logic          lock_p0;
  logic          lock_p1;
  logic [SW-1:0] stable_cnt;
  logic [TW-1:0] tmo_cnt;

  // Two-flop synchroniser: LOCK comes from the PLL, not from CLK.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_p0 <= 1'b0;
      lock_p1 <= 1'b0;
    end else begin
      lock_p0 <= lock;
      lock_p1 <= lock_p0;
    end
  end

  // Saturating stable/timeout counters; any low LOCK cycle restarts the stable run.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stable_cnt <= '0;
      tmo_cnt    <= '0;
    end else if (clear) begin
      stable_cnt <= '0;
      tmo_cnt    <= '0;
    end else if (enable) begin
      if (!lock_p1)
        stable_cnt <= '0;
      else if (stable_cnt != STABLE_MAX)
        stable_cnt <= stable_cnt + 1'b1;
      if (tmo_cnt != TMO_MAX)
        tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  assign locked  = (stable_cnt == STABLE_MAX);
  // Fires on the LOCK_TIMEOUT-th enabled cycle, so the FSM dwells exactly that long.
  assign timeout = enable && (tmo_cnt == TMO_LAST);

endmodule

// File: rtl/ccc_apb_reconfig_master.sv
// APB initiator for the CCC dynamic-reconfiguration port: holds the PLL in
// reset, writes the register table, optionally reads it back, releases the
// PLL and waits for a qualified lock. All outputs are registered.
module ccc_apb_reconfig_master
  import ccc_cfg_pkg::*;
#(
  parameter int NREG         = 4,
  parameter int VERIFY       = 1,
  parameter int LOCK_TIMEOUT = 4096,
  parameter int LOCK_STABLE  = 16,
  parameter int BUSY_TIMEOUT = 64
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   START,
  input  logic [NREG*APB_AW-1:0] CFG_ADDR,
  input  logic [NREG*APB_DW-1:0] CFG_DATA,
  output logic                   PSEL,
  output logic                   PENABLE,
  output logic                   PWRITE,
  output logic [APB_AW-1:0]      PADDR,
  output logic [APB_DW-1:0]      PWDATA,
  input  logic [APB_DW-1:0]      PRDATA,
  input  logic                   CCC_BUSY,
  input  logic                   LOCK,
  output logic                   PLL_ARST_N,
  output logic                   BUSY,
  output logic                   DONE,
  output logic                   ERR,
  output logic [1:0]             ERR_CODE
);

  localparam int IDX_W = (NREG > 1) ? $clog2(NREG) : 1;
  localparam int BW    = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NREG - 1);
  localparam logic [BW-1:0]    BUSY_LAST = BW'(BUSY_TIMEOUT - 1);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [BW-1:0]      bcnt_q, bcnt_d;
  logic [1:0]         code_d;
  logic               capture;
  logic               lq_clear;
  logic               lq_en;
  logic               locked;
  logic               lock_tmo;

  logic [APB_AW-1:0]  addr_tab [NREG];
  logic [APB_DW-1:0]  data_tab [NREG];

  ccc_lock_qualifier #(
    .LOCK_TIMEOUT (LOCK_TIMEOUT),
    .LOCK_STABLE  (LOCK_STABLE)
  ) u_lockq (
    .clk     (CLK),
    .rst     (RST),
    .lock    (LOCK),
    .clear   (lq_clear),
    .enable  (lq_en),
    .locked  (locked),
    .timeout (lock_tmo)
  );

  // Register table snapshot taken when a sequence is accepted.
  always_ff @(posedge CLK) begin
    if (capture) begin
      for (int i = 0; i < NREG; i++) begin
        addr_tab[i] <= CFG_ADDR[i*APB_AW +: APB_AW];
        data_tab[i] <= CFG_DATA[i*APB_DW +: APB_DW];
      end
    end
  end

  // FSM state, table index and ACCESS stretch counter.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      idx_q   <= '0;
      bcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      bcnt_q  <= bcnt_d;
    end
  end

  // Next-state, index/stretch update and failure code selection.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    bcnt_d   = bcnt_q;
    code_d   = ERR_NONE;
    capture  = 1'b0;
    lq_clear = 1'b0;
    lq_en    = 1'b0;
    case (state_q)
      IDLE: begin
        if (START) begin
          capture = 1'b1;
          idx_d   = '0;
          state_d = PLL_HOLD;
        end
      end
      PLL_HOLD: state_d = W_SETUP;
      W_SETUP: begin
        bcnt_d  = '0;
        state_d = W_ACCESS;
      end
      W_ACCESS: begin
        if (!CCC_BUSY) begin
          if (idx_q == IDX_LAST) begin
            idx_d   = '0;
            state_d = (VERIFY != 0) ? R_SETUP : RELEASE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = W_SETUP;
          end
        end else if (bcnt_q == BUSY_LAST) begin
          code_d  = ERR_BUSY_TMO;
          state_d = FAIL;
        end else begin
          bcnt_d = bcnt_q + 1'b1;
        end
      end
      R_SETUP: begin
        bcnt_d  = '0;
        state_d = R_ACCESS;
      end
      R_ACCESS: begin
        if (!CCC_BUSY) begin
          if (PRDATA != data_tab[idx_q]) begin
            code_d  = ERR_MISMATCH;
            state_d = FAIL;
          end else if (idx_q == IDX_LAST) begin
            state_d = RELEASE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = R_SETUP;
          end
        end else if (bcnt_q == BUSY_LAST) begin
          code_d  = ERR_BUSY_TMO;
          state_d = FAIL;
        end else begin
          bcnt_d = bcnt_q + 1'b1;
        end
      end
      RELEASE: begin
        lq_clear = 1'b1;
        state_d  = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        lq_en = 1'b1;
        // A lock qualifying on the timeout cycle still counts as success.
        if (locked) begin
          state_d = SUCCESS;
        end else if (lock_tmo) begin
          code_d  = ERR_LOCK_TMO;
          state_d = FAIL;
        end
      end
      SUCCESS: state_d = IDLE;
      FAIL:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Registered outputs decoded from the state being entered.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      PSEL       <= 1'b0;
      PENABLE    <= 1'b0;
      PWRITE     <= 1'b0;
      PADDR      <= '0;
      PWDATA     <= '0;
      PLL_ARST_N <= 1'b1;
      BUSY       <= 1'b0;
      DONE       <= 1'b0;
      ERR        <= 1'b0;
      ERR_CODE   <= ERR_NONE;
    end else begin
      PSEL       <= in_apb(state_d);
      PENABLE    <= (state_d == W_ACCESS) || (state_d == R_ACCESS);
      PWRITE     <= (state_d == W_SETUP) || (state_d == W_ACCESS);
      if ((state_d == W_SETUP) || (state_d == R_SETUP))
        PADDR <= addr_tab[idx_d];
      if (state_d == W_SETUP)
        PWDATA <= data_tab[idx_d];
      PLL_ARST_N <= !holds_pll(state_d);
      BUSY       <= !(state_d inside {IDLE, SUCCESS, FAIL});
      DONE       <= (state_d == SUCCESS);
      ERR        <= (state_d == FAIL);
      if (capture)
        ERR_CODE <= ERR_NONE;
      else if (state_d == FAIL)
        ERR_CODE <= code_d;
    end
  end

endmodule
